// File: rtl/best_pkg.sv
// Shared definitions for the best-track ring buffer: widths, readout state
// encoding and the occupancy helper also used by the writer-side full logic.
package best_pkg;

  localparam int BEST_AW = 8;
  localparam int BEST_DW = 36;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  // Words buffered between begin and writer pointers; equal pointers mean empty.
  function automatic logic [BEST_AW-1:0] ring_avail(input logic [BEST_AW-1:0] adw,
                                                    input logic [BEST_AW-1:0] adb);
    return adw - adb;
  endfunction

endpackage

// File: rtl/best_readout.sv
// Read-side controller for the best-track ring buffer: streams complete event
// blocks out of the RAM and releases them to the writer once fully accepted.
module best_readout
  import best_pkg::*;
#(
  parameter int AW = BEST_AW,
  parameter int DW = BEST_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] adw,
  input  logic [AW-1:0] wblock,
  input  logic          en,
  input  logic          flush,
  input  logic [DW-1:0] dr,
  output logic [AW-1:0] adr,
  output logic [AW-1:0] adb,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          ev_avail,
  output logic [15:0]   ev_count
);

  logic [0:0]    state_reg;
  logic [AW-1:0] rp_reg;
  logic [AW-1:0] adb_reg;
  logic [AW-1:0] wblk_reg;
  logic [AW-1:0] cnt_reg;
  logic [15:0]   ev_count_reg;
  logic [AW-1:0] avail;
  logic [AW-1:0] blk_end;
  logic          fire;

  always_comb begin
    avail      = ring_avail(adw, adb_reg);
    ev_avail   = (wblock != '0) && (avail >= wblock);
    dout_valid = (state_reg == STREAM);
    busy       = dout_valid;
    dout_last  = dout_valid && (cnt_reg == AW'(1));
    fire       = dout_valid && dout_ready;
    blk_end    = adb_reg + wblk_reg;
    // Present the next address early so the RAM register already holds it
    // when the following word is due; a stall keeps it parked on rp.
    adr        = fire ? rp_reg + AW'(1) : rp_reg;
    dout       = dr;
    adb        = adb_reg;
    ev_count   = ev_count_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rp_reg       <= '0;
      adb_reg      <= '0;
      wblk_reg     <= '0;
      cnt_reg      <= '0;
      ev_count_reg <= '0;
    end else if (flush) begin
      adb_reg   <= adw;
      rp_reg    <= adw;
      state_reg <= IDLE;
    end else if (state_reg == IDLE) begin
      rp_reg <= adb_reg;
      if (en && ev_avail) begin
        wblk_reg  <= wblock;
        cnt_reg   <= wblock;
        state_reg <= STREAM;
      end
    end else if (fire) begin
      if (cnt_reg == AW'(1)) begin
        // Release the whole block to the writer only once its last word is taken.
        adb_reg      <= blk_end;
        rp_reg       <= blk_end;
        ev_count_reg <= ev_count_reg + 16'd1;
        state_reg    <= IDLE;
      end else begin
        rp_reg  <= rp_reg + AW'(1);
        cnt_reg <= cnt_reg - AW'(1);
      end
    end
  end

endmodule
